// File: rtl/alu_uart_sequencer.sv
// Frame controller between a UART RX/TX pair and an ALU: collects operand A, operand B
// and opcode bytes, drives the ALU buses, and returns the result through the transmitter.
module alu_uart_sequencer #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_op_error,
  output logic               o_overrun
);

  typedef enum logic [2:0] {
    ST_WAIT_A,
    ST_WAIT_B,
    ST_WAIT_OP,
    ST_COMPUTE,
    ST_SEND,
    ST_WAIT_TX
  } state_t;

  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'h20);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'h22);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'h24);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'h25);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'h26);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'h03);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'h02);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'h27);

  state_t             r_state;
  state_t             w_next_state;
  logic [NB_DATA-1:0] r_alu_a;
  logic [NB_DATA-1:0] r_alu_b;
  logic [NB_OP-1:0]   r_alu_op;
  logic [NB_DATA-1:0] r_tx_data;
  logic               r_op_error;
  logic               r_overrun;
  logic               w_op_valid;
  logic               w_busy;
  logic [NB_DATA-1:0] w_rx_upper;

  // Any bit above the opcode field makes the byte invalid, even if the low bits match.
  assign w_rx_upper = i_rx_data >> NB_OP;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_op_valid = 1'b0;
    if (w_rx_upper == '0) begin
      case (i_rx_data[NB_OP-1:0])
        OP_ADD, OP_SUB, OP_AND, OP_OR,
        OP_XOR, OP_SRA, OP_SRL, OP_NOR: w_op_valid = 1'b1;
        default:                        w_op_valid = 1'b0;
      endcase
    end
  end

  assign w_busy = (r_state == ST_COMPUTE) || (r_state == ST_SEND) || (r_state == ST_WAIT_TX);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= ST_WAIT_A;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_WAIT_A:  if (i_rx_done) w_next_state = ST_WAIT_B;
      ST_WAIT_B:  if (i_rx_done) w_next_state = ST_WAIT_OP;
      ST_WAIT_OP: if (i_rx_done) w_next_state = w_op_valid ? ST_COMPUTE : ST_WAIT_A;
      ST_COMPUTE: w_next_state = ST_SEND;
      ST_SEND:    w_next_state = ST_WAIT_TX;
      ST_WAIT_TX: if (i_tx_done) w_next_state = ST_WAIT_A;
      default:    w_next_state = ST_WAIT_A;
    endcase
  end

  // Operands and opcode are part of the reset domain so a mid-frame reset clears the ALU inputs.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_op   <= '0;
      r_tx_data  <= '0;
      r_op_error <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      r_op_error <= 1'b0;
      case (r_state)
        ST_WAIT_A: if (i_rx_done) r_alu_a <= i_rx_data;
        ST_WAIT_B: if (i_rx_done) r_alu_b <= i_rx_data;
        ST_WAIT_OP: begin
          if (i_rx_done) begin
            if (w_op_valid) r_alu_op   <= i_rx_data[NB_OP-1:0];
            else            r_op_error <= 1'b1;
          end
        end
        ST_COMPUTE: r_tx_data <= i_alu_result;
        default: ;
      endcase
      if (i_rx_done && w_busy) r_overrun <= 1'b1;
    end
  end

  assign o_alu_a    = r_alu_a;
  assign o_alu_b    = r_alu_b;
  assign o_alu_op   = r_alu_op;
  assign o_tx_data  = r_tx_data;
  assign o_tx_start = (r_state == ST_SEND);
  assign o_busy     = w_busy;
  assign o_op_error = r_op_error;
  assign o_overrun  = r_overrun;

endmodule
